// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg -- constants shared by the multicycle MIPS controller and datapath.
//
// Contents:
//   S_*      4-bit state codes of the multicycle control FSM
//   OP_*     6-bit primary opcodes (inst[31:26]) the machine supports
//   ALU_*    ALUOp codes       (add / sub / funct-decoded)
//   SRCB_*   ALUSrcB mux codes (B / 4 / sign-extended imm / imm<<2)
//   PCSRC_*  PCSource mux codes (ALU / ALUOut / jump target)
//   ctrl_t   bundle of every control output, decoded once per state
//   is_legal_opcode()  true for the opcodes the FSM can execute
// -----------------------------------------------------------------------------
package mips_pkg;

    // FSM state encoding
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALUOp codes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALUSrcB mux codes
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PCSource mux codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       inst_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) ||
               (op == OP_ADDI)  || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control -- control FSM of a multicycle MIPS subset
// (R-type, lw, sw, beq, j, addi).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   opcode[5:0]       inst[31:26] from the instruction register
//   mem_ready         memory finishes the current access this cycle
//   PCWrite .. PCSource  datapath control (see mips_pkg for mux codes)
//   inst_done         pulse on the last cycle of every legal instruction
//   illegal_op        pulse in DECODE for an unsupported opcode
//   state[3:0]        current state code (debug)
//
// Structure: one state register, a combinational next-state block and a
// combinational output decode. Outputs are Moore-style except the
// mem_ready-qualified strobes in FETCH and MEM_WRITE.
// -----------------------------------------------------------------------------
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       inst_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first, so no path through the case
        // leaves state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;   // illegal: acts as nop
                endcase
            end
            // Only lw/sw reach here; anything other than sw is treated as a load.
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                         state_d = S_FETCH;
            default:     state_d = S_FETCH;            // unused codes recover
        endcase
    end

    // Output decode; everything not named for a state stays 0.
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;   // precompute branch target
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_legal_opcode(opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.inst_done  = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.inst_done = mem_ready;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.inst_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.inst_done     = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.inst_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.inst_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // Reset silences the datapath immediately, even mid-access.
        if (rst) ctrl = '0;
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign inst_done   = ctrl.inst_done;
    assign illegal_op  = ctrl.illegal_op;
    assign state       = state_q;

endmodule
